// File: rtl/store_buffer_lsu_if.sv
// Bundle of signals between store_buffer_lsu and its environment.
// The environment is the CPU request side plus the data memory.
// slave  : the LSU itself.
// master : the pipeline and memory that drive it.
interface store_buffer_lsu_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 3
);
   logic              req_valid;
   logic              req_ready;
   logic              req_rw;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              mem_en;
   logic              mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic [CNT_W-1:0]  count;

   modport slave (
      input  req_valid, req_rw, req_addr, req_wdata, mem_rdata, mem_ready,
      output req_ready, rsp_valid, rsp_data, mem_en, mem_rw, mem_addr, mem_wdata, count
   );

   modport master (
      output req_valid, req_rw, req_addr, req_wdata, mem_rdata, mem_ready,
      input  req_ready, rsp_valid, rsp_data, mem_en, mem_rw, mem_addr, mem_wdata, count
   );
endinterface

// File: rtl/store_buffer_lsu.sv
// Load/store front-end. Stores are queued in a DEPTH-entry FIFO and
// drained in order into data memory. Loads are issued as reads and their
// data is returned to writeback.
// Optional feature macro: LOAD_FORWARD_EN. When it is defined, loads may be
// accepted while stores are buffered. A load that hits a buffered store
// returns the youngest matching data. A load that misses reads memory ahead
// of the buffered stores.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no read in flight (a load may be held waiting for mem_ready)
// LD_WAIT  | read issued, counting down MEM_RD_LAT to the capture cycle
// LD_RSP   | rsp_valid pulse with captured or forwarded data
module store_buffer_lsu #(
   parameter int DEPTH      = 4,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_RD_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   store_buffer_lsu_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int LAT_W = $clog2(MEM_RD_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_LD_WAIT, S_LD_RSP} state_t;

   state_t            r_state, w_next_state;
   logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
   logic [DATA_W-1:0] r_fifo_data [DEPTH];
   logic [PTR_W-1:0]  r_head, r_tail;
   logic [CNT_W-1:0]  r_count;
   logic              r_ld_pend;
   logic [ADDR_W-1:0] r_ld_addr;
   logic [LAT_W-1:0]  r_lat_cnt;
   logic              r_mem_en, r_mem_rw;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_rsp_data;

   logic              w_full, w_ld_ok, w_req_ready;
   logic              w_st_acc, w_ld_acc, w_ld_miss_now;
   logic              w_ld_issue, w_pop, w_rsp_valid;
   logic [ADDR_W-1:0] w_ld_issue_addr;
   logic              w_fwd_hit;

`ifdef LOAD_FORWARD_EN
   logic [DATA_W-1:0] w_fwd_data;

   // Search the buffer oldest to youngest so that the youngest match wins.
   always_comb begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < r_count) &&
             (r_fifo_addr[r_head + PTR_W'(i)] == bus.req_addr)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_fifo_data[r_head + PTR_W'(i)];
         end
      end
   end
`else
   assign w_fwd_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state logic: a forwarded hit skips the memory read entirely.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_ld_acc && w_fwd_hit) w_next_state = S_LD_RSP;
            else if (w_ld_issue)       w_next_state = S_LD_WAIT;
         end
         S_LD_WAIT: if (r_lat_cnt == '0) w_next_state = S_LD_RSP;
         S_LD_RSP:  w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   // Handshake and issue arbitration: a pending load read beats a store drain.
   always_comb begin
      w_full = (r_count == CNT_W'(DEPTH));
`ifdef LOAD_FORWARD_EN
      w_ld_ok = (r_state == S_IDLE) && !r_ld_pend;
`else
      w_ld_ok = (r_state == S_IDLE) && !r_ld_pend && (r_count == '0);
`endif
      w_req_ready     = bus.req_rw ? !w_full : w_ld_ok;
      w_st_acc        = bus.req_valid && w_req_ready && bus.req_rw;
      w_ld_acc        = bus.req_valid && w_req_ready && !bus.req_rw;
      w_ld_miss_now   = w_ld_acc && !w_fwd_hit;
      w_ld_issue      = bus.mem_ready && (r_state == S_IDLE) && (r_ld_pend || w_ld_miss_now);
      w_ld_issue_addr = r_ld_pend ? r_ld_addr : bus.req_addr;
      w_pop           = bus.mem_ready && (r_state != S_LD_WAIT) && !w_ld_issue && (r_count != '0);
      w_rsp_valid     = (r_state == S_LD_RSP);
   end

   // Store buffer storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (w_st_acc) begin
         r_fifo_addr[r_tail] <= bus.req_addr;
         r_fifo_data[r_tail] <= bus.req_wdata;
      end
   end

   // Pointers, memory strobe, held load, read latency timer and response data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_ld_pend   <= 1'b0;
         r_ld_addr   <= '0;
         r_lat_cnt   <= '0;
         r_mem_en    <= 1'b0;
         r_mem_rw    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rsp_data  <= '0;
      end else begin
         r_mem_en <= 1'b0;
         if (w_ld_issue) begin
            r_mem_en   <= 1'b1;
            r_mem_rw   <= 1'b0;
            r_mem_addr <= w_ld_issue_addr;
         end else if (w_pop) begin
            r_mem_en    <= 1'b1;
            r_mem_rw    <= 1'b1;
            r_mem_addr  <= r_fifo_addr[r_head];
            r_mem_wdata <= r_fifo_data[r_head];
            r_head      <= r_head + PTR_W'(1);
         end
         if (w_st_acc) r_tail <= r_tail + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_st_acc) - CNT_W'(w_pop);

         if (w_ld_issue) begin
            r_ld_pend <= 1'b0;
         end else if (w_ld_miss_now) begin
            r_ld_pend <= 1'b1;
            r_ld_addr <= bus.req_addr;
         end

         if (w_ld_issue)
            r_lat_cnt <= LAT_W'(MEM_RD_LAT);
         else if ((r_state == S_LD_WAIT) && (r_lat_cnt != '0))
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);

         if ((r_state == S_LD_WAIT) && (r_lat_cnt == '0))
            r_rsp_data <= bus.mem_rdata;
`ifdef LOAD_FORWARD_EN
         else if (w_ld_acc && w_fwd_hit)
            r_rsp_data <= w_fwd_data;
`endif
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.mem_en    = r_mem_en;
   assign bus.mem_rw    = r_mem_rw;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.count     = r_count;
endmodule

// File: tb/tb_store_buffer_lsu.sv
// Bench for store_buffer_lsu: directed scenarios followed by random traffic,
// all checked against a program-order model of memory and a queue of
// stores awaiting their memory write.
module tb_store_buffer_lsu;
   localparam int DEPTH = 4;
   localparam int LAT   = 1;
`ifdef LOAD_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   store_buffer_lsu_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(3)) bus ();

   store_buffer_lsu #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .MEM_RD_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Data memory model: writes commit at the end of the mem_en cycle,
   // read data is presented only in cycle T+LAT.
   logic [31:0] mem [logic [31:0]];
   logic [31:0] rd_pipe [LAT];
   logic [LAT-1:0] rd_vld;

   function automatic logic [31:0] mem_init(input logic [31:0] a);
      return (a == 32'd4) ? 32'hDEADBEEF : (a ^ 32'h5A5A0000);
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : mem_init(a);
   endfunction

   always @(posedge clk) begin
      if (!rst && bus.mem_en && bus.mem_rw) mem[bus.mem_addr] = bus.mem_wdata;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld <= '0;
      end else begin
         for (int k = LAT - 1; k > 0; k--) begin
            rd_vld[k]  <= rd_vld[k-1];
            rd_pipe[k] <= rd_pipe[k-1];
         end
         rd_vld[0]  <= bus.mem_en && !bus.mem_rw;
         rd_pipe[0] <= mem_rd(bus.mem_addr);
      end
   end

   assign bus.mem_rdata = rd_vld[LAT-1] ? rd_pipe[LAT-1] : 32'hBADBADBA;

   // Reference model state.
   typedef struct packed { logic [31:0] a; logic [31:0] d; } st_t;
   st_t wq [$];
   logic [31:0] ref_mem [logic [31:0]];
   int   n_chk = 0, n_pass = 0, n_fail = 0;
   int   cyc = 0, n_wr = 0, n_rsp = 0;
   bit   ld_out = 0, ld_fwd = 0, ld_issued = 0;
   logic [31:0] ld_addr, ld_exp;
   int   ld_acc_cyc = 0, ld_issue_cyc = 0;

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
   endfunction

   function automatic bit in_q(input logic [31:0] a);
      foreach (wq[i]) if (wq[i].a == a) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input bit rw, input logic [31:0] a, input logic [31:0] d);
      bus.req_valid = v;
      bus.req_rw    = rw;
      bus.req_addr  = a;
      bus.req_wdata = d;
   endtask

   // One clock cycle: observe at the falling edge, update the model for
   // whatever the rising edge accepts, return 1 time unit after it.
   task automatic step();
      bit acc, saw_rsp, exp_rdy;
      st_t e;
      @(negedge clk);
      if (bus.mem_en && bus.mem_rw) begin
         n_wr++;
         chk("wr_pending", 64'(wq.size() != 0), 64'(1));
         if (wq.size() != 0) begin
            e = wq.pop_front();
            chk("wr_addr", 64'(bus.mem_addr), 64'(e.a));
            chk("wr_data", 64'(bus.mem_wdata), 64'(e.d));
         end
      end
      if (bus.mem_en && !bus.mem_rw) begin
         chk("rd_expected", 64'(ld_out && !ld_fwd && !ld_issued), 64'(1));
         chk("rd_addr", 64'(bus.mem_addr), 64'(ld_addr));
         ld_issued    = 1'b1;
         ld_issue_cyc = cyc;
      end
      saw_rsp = bus.rsp_valid;
      if (saw_rsp) begin
         n_rsp++;
         chk("rsp_expected", 64'(ld_out), 64'(1));
         chk("rsp_data", 64'(bus.rsp_data), 64'(ld_exp));
         chk("rsp_cycle", 64'(cyc), 64'(ld_fwd ? ld_acc_cyc + 1 : ld_issue_cyc + LAT + 1));
      end
      chk("count", 64'(bus.count), 64'(wq.size()));
      exp_rdy = bus.req_rw ? (wq.size() < DEPTH) : (!ld_out && (FWD || wq.size() == 0));
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      acc = bus.req_valid && bus.req_ready;
      if (saw_rsp) ld_out = 1'b0;
      if (acc && bus.req_rw) begin
         wq.push_back('{a: bus.req_addr, d: bus.req_wdata});
         ref_mem[bus.req_addr] = bus.req_wdata;
      end
      if (acc && !bus.req_rw) begin
         ld_out     = 1'b1;
         ld_issued  = 1'b0;
         ld_addr    = bus.req_addr;
         ld_exp     = ref_rd(bus.req_addr);
         ld_acc_cyc = cyc;
         ld_fwd     = FWD && in_q(bus.req_addr);
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 60 && (wq.size() != 0 || ld_out); k++) step();
      chk(tag, 64'(wq.size() == 0 && !ld_out), 64'(1));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_count"},     64'(bus.count), 64'(0));
      chk({tag, "_mem_en"},    64'(bus.mem_en), 64'(0));
      chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
      chk({tag, "_rsp_data"},  64'(bus.rsp_data), 64'(0));
   endtask

   initial begin
      int wr0, rsp0;
      drive(0, 0, 0, 0);
      bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      chk("reset_mem_addr", 64'(bus.mem_addr), 64'(0));
      chk("reset_mem_rw", 64'(bus.mem_rw), 64'(0));
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;

      // Back-to-back stores with memory always ready drain in order.
      bus.mem_ready = 1'b1;
      wr0 = n_wr;
      drive(1, 1, 0, 32'hA); step();
      drive(1, 1, 1, 32'hB); step();
      drive(1, 1, 2, 32'hC); step();
      drive(0, 1, 0, 0);
      drain("t2_drain");
      step();
      chk("t2_writes", 64'(n_wr - wr0), 64'(3));
      chk("t2_count", 64'(bus.count), 64'(0));

      // Memory stalled: the fifth store is held off until a slot frees.
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 32'(16 + i), 32'(32'h100 + i));
         step();
      end
      drive(1, 1, 20, 32'h104);
      #1;
      chk("t3_full_ready", 64'(bus.req_ready), 64'(0));
      chk("t3_count_full", 64'(bus.count), 64'(4));
      step();
      bus.mem_ready = 1'b1;
      step();
      chk("t3_ready_after_pop", 64'(bus.req_ready), 64'(1));
      step();
      drive(0, 1, 0, 0);
      drain("t3_drain");

`ifdef LOAD_FORWARD_EN
      // A load hitting buffered stores takes the youngest data, no memory read.
      bus.mem_ready = 1'b0;
      drive(1, 1, 7, 32'h1); step();
      drive(1, 1, 7, 32'h2); step();
      drive(1, 0, 7, 0);     step();
      drive(0, 1, 0, 0);
      chk("t4_rsp_valid", 64'(bus.rsp_valid), 64'(1));
      chk("t4_rsp_data", 64'(bus.rsp_data), 64'(2));
      chk("t4_no_mem", 64'(bus.mem_en), 64'(0));
      step();
      bus.mem_ready = 1'b1;
      drain("t4_drain");
`else
      // A load waits for the buffer to drain before issuing.
      bus.mem_ready = 1'b0;
      drive(1, 1, 3, 32'h55); step();
      drive(1, 0, 9, 0);
      #1;
      chk("t5_load_blocked", 64'(bus.req_ready), 64'(0));
      step();
      bus.mem_ready = 1'b1;
      for (int k = 0; k < 20 && !ld_out; k++) step();
      chk("t5_load_accepted", 64'(ld_out), 64'(1));
      drive(0, 1, 0, 0);
      drain("t5_drain");
`endif

      // Plain load from an empty buffer returns memory data once.
      rsp0 = n_rsp;
      drive(1, 0, 4, 0); step();
      drive(0, 1, 0, 0);
      drain("t6_done");
      repeat (3) step();
      chk("t6_single_rsp", 64'(n_rsp - rsp0), 64'(1));
      chk("t6_data", 64'(bus.rsp_data), 64'(32'hDEADBEEF));

      // Reset in the middle of a drain discards everything buffered.
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 32'(40 + i), 32'(32'h77 + i));
         step();
      end
      drive(0, 1, 0, 0);
      bus.mem_ready = 1'b1;
      step();
      rst = 1'b1;
      #2;
      chk_reset_outputs("t1_rst");
      wq.delete();
      ld_out  = 1'b0;
      ref_mem = mem;
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      wr0 = n_wr;
      repeat (5) step();
      chk("t1_no_writes", 64'(n_wr - wr0), 64'(0));

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         bus.mem_ready = ($urandom_range(0, 3) != 0);
         drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
         step();
      end
      drive(0, 1, 0, 0);
      bus.mem_ready = 1'b1;
      drain("rand_drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
